// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The master side is the sequencer: it reads instruction fields and memory
// status, and it drives every datapath enable and mux select.
interface mips_multicycle_control_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_source;
  logic        ir_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_toreg;
  logic [1:0]  reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [3:0]  state;
  logic        instr_retired;
  logic [31:0] retired_count;
  logic        err_illegal_opcode;
  logic        err_mem_timeout;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
           mem_write, mem_toreg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, state, instr_retired, retired_count, err_illegal_opcode,
           err_mem_timeout
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
           mem_write, mem_toreg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, state, instr_retired, retired_count, err_illegal_opcode,
           err_mem_timeout
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM. Steps each instruction through fetch, decode,
// execute, memory and writeback over one shared memory port, waits on
// mem_ready with a bounded wait counter, and counts retired instructions.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic                       clock,
  input logic                       reset_n,
  mips_multicycle_control_if.master bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADDR  = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_RTYPEWB  = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_IMMEXEC  = 4'd10;
  localparam logic [3:0] S_IMMWB    = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_ERROR    = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Counter value seen on the last permitted wait cycle; a miss here times out.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0]  state_reg, state_next;
  logic [7:0]  wait_reg;
  logic [31:0] retired_reg;
  logic        err_illegal_reg, err_timeout_reg;
  logic        mem_wait_state, timeout_hit, illegal_hit, retire;
  logic        unused_inputs;

  // funct goes to ALU control and alu_zero gates pc_write_cond in the datapath.
  assign unused_inputs = ^{bus.funct, bus.alu_zero};

  assign mem_wait_state = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                          (state_reg == S_MEMWRITE);
  // mem_ready on the final allowed cycle wins over the timeout.
  assign timeout_hit = mem_wait_state && !bus.mem_ready && (wait_reg == WAIT_LAST);

  assign bus.state              = state_reg;
  assign bus.retired_count      = retired_reg;
  assign bus.err_illegal_opcode = err_illegal_reg;
  assign bus.err_mem_timeout    = err_timeout_reg;
  assign bus.instr_retired      = retire;

  // Next-state selection, including opcode dispatch and error entry.
  always_comb begin
    state_next  = state_reg;
    illegal_hit = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (bus.mem_ready)  state_next = S_DECODE;
        else if (timeout_hit) state_next = S_ERROR;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_LW, OP_SW: state_next = S_MEMADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_JAL:       state_next = S_JAL;
          OP_ADDI:      state_next = S_IMMEXEC;
          default: begin
            state_next  = S_ERROR;
            illegal_hit = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_next = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (bus.mem_ready)  state_next = S_MEMWB;
        else if (timeout_hit) state_next = S_ERROR;
      end
      S_MEMWRITE: begin
        if (bus.mem_ready)  state_next = S_FETCH;
        else if (timeout_hit) state_next = S_ERROR;
      end
      S_EXECUTE:                                    state_next = S_RTYPEWB;
      S_IMMEXEC:                                    state_next = S_IMMWB;
      S_MEMWB, S_RTYPEWB, S_IMMWB, S_BRANCH, S_JUMP, S_JAL: state_next = S_FETCH;
      S_ERROR:                                      state_next = S_ERROR;
      default:                                      state_next = S_ERROR;
    endcase
  end

  // Per-state control outputs; everything is held low while reset_n is low.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'd0;
    bus.ir_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_toreg     = 2'd0;
    bus.reg_dst       = 2'd0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.alu_op        = 2'd0;
    retire            = 1'b0;
    if (reset_n) begin
      case (state_reg)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'd1;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: bus.alu_src_b = 2'd3;
        S_MEMADDR, S_IMMEXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'd2;
        end
        S_MEMREAD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write = 1'b1;
          bus.mem_toreg = 2'd1;
          retire        = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
          retire        = bus.mem_ready;
        end
        S_EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'd2;
        end
        S_RTYPEWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 2'd1;
          retire        = 1'b1;
        end
        S_IMMWB: begin
          bus.reg_write = 1'b1;
          retire        = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'd1;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'd1;
          retire            = 1'b1;
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'd2;
          retire        = 1'b1;
        end
        S_JAL: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 2'd2;
          bus.mem_toreg = 2'd2;
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'd2;
          retire        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register and memory wait counter; any state change restarts the count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
      wait_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        wait_reg <= 8'd0;
      else if (mem_wait_state && !bus.mem_ready)
        wait_reg <= wait_reg + 8'd1;
    end
  end

  // Retired-instruction counter (wraps naturally) and sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      retired_reg     <= 32'd0;
      err_illegal_reg <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (retire)      retired_reg     <= retired_reg + 32'd1;
      if (illegal_hit) err_illegal_reg <= 1'b1;
      if (timeout_hit) err_timeout_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: a directed cycle table, hand-written
// error sequences, and random instruction streams checked against a
// per-instruction expected-cycle plan built from the instruction class.
module tb_mips_multicycle_control;
  localparam int TO = 4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_toreg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_retired;
  } ctl_t;

  typedef struct {
    bit          rst_n;
    logic [5:0]  op;
    bit          rdy;
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    bit         rdy;
    logic [3:0] st;
    ctl_t       ctl;
  } cyc_t;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_no   = 0;
  vec_t tbl[$];
  cyc_t exp_q[$];
  int   err_kind;

  mips_multicycle_control_if bus();

  mips_multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // Expected control word for each step of an instruction.
  function automatic ctl_t c_none();
    ctl_t c = '0;
    return c;
  endfunction
  function automatic ctl_t c_fetch(bit rdy);
    ctl_t c = '0;
    c.mem_read = 1; c.alu_src_b = 2'd1; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctl_t c_decode();
    ctl_t c = '0;
    c.alu_src_b = 2'd3;
    return c;
  endfunction
  function automatic ctl_t c_addr();
    ctl_t c = '0;
    c.alu_src_a = 1; c.alu_src_b = 2'd2;
    return c;
  endfunction
  function automatic ctl_t c_memread();
    ctl_t c = '0;
    c.mem_read = 1; c.iord = 1;
    return c;
  endfunction
  function automatic ctl_t c_memwb();
    ctl_t c = '0;
    c.reg_write = 1; c.mem_toreg = 2'd1; c.instr_retired = 1;
    return c;
  endfunction
  function automatic ctl_t c_memwrite(bit rdy);
    ctl_t c = '0;
    c.mem_write = 1; c.iord = 1; c.instr_retired = rdy;
    return c;
  endfunction
  function automatic ctl_t c_exec();
    ctl_t c = '0;
    c.alu_src_a = 1; c.alu_op = 2'd2;
    return c;
  endfunction
  function automatic ctl_t c_wb(logic [1:0] dst);
    ctl_t c = '0;
    c.reg_write = 1; c.reg_dst = dst; c.instr_retired = 1;
    return c;
  endfunction
  function automatic ctl_t c_branch();
    ctl_t c = '0;
    c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_write_cond = 1; c.pc_source = 2'd1;
    c.instr_retired = 1;
    return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c = '0;
    c.pc_write = 1; c.pc_source = 2'd2; c.instr_retired = 1;
    return c;
  endfunction
  function automatic ctl_t c_jal();
    ctl_t c = '0;
    c.reg_write = 1; c.reg_dst = 2'd2; c.mem_toreg = 2'd2; c.pc_write = 1;
    c.pc_source = 2'd2; c.instr_retired = 1;
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.pc_write      = bus.pc_write;
    c.pc_write_cond = bus.pc_write_cond;
    c.pc_source     = bus.pc_source;
    c.ir_write      = bus.ir_write;
    c.iord          = bus.iord;
    c.mem_read      = bus.mem_read;
    c.mem_write     = bus.mem_write;
    c.mem_toreg     = bus.mem_toreg;
    c.reg_dst       = bus.reg_dst;
    c.reg_write     = bus.reg_write;
    c.alu_src_a     = bus.alu_src_a;
    c.alu_src_b     = bus.alu_src_b;
    c.alu_op        = bus.alu_op;
    c.instr_retired = bus.instr_retired;
    return c;
  endfunction

  function automatic logic [31:0] ctl_u32(ctl_t c);
    logic [31:0] v = '0;
    v[$bits(ctl_t)-1:0] = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_no, got, exp);
  endtask

  // Drive one clock's inputs at the falling edge, then check all outputs.
  task automatic do_cycle(input bit rst_n, input logic [5:0] op, input bit rdy,
                          input logic [3:0] st, input ctl_t c, input logic [31:0] cnt,
                          input logic [1:0] errs);
    @(negedge clock);
    reset_n       = rst_n;
    bus.opcode    = op;
    bus.funct     = 6'($urandom);
    bus.mem_ready = rdy;
    bus.alu_zero  = 1'($urandom_range(0, 1));
    #1;
    cyc_no++;
    chk("state", {28'd0, bus.state}, {28'd0, st});
    chk("ctl", ctl_u32(dut_ctl()), ctl_u32(c));
    chk("retired_count", bus.retired_count, cnt);
    chk("err_flags", {30'd0, bus.err_illegal_opcode, bus.err_mem_timeout}, {30'd0, errs});
  endtask

  task automatic add(input bit rst_n, input logic [5:0] op, input bit rdy,
                     input logic [3:0] st, input ctl_t c, input logic [31:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic push(input bit rdy, input logic [3:0] st, input ctl_t c);
    cyc_t e;
    e.rdy = rdy; e.st = st; e.ctl = c;
    exp_q.push_back(e);
  endtask

  // A memory access: w missed cycles then a ready cycle, or a timeout.
  task automatic mem_phase(input logic [3:0] st, input ctl_t wait_c, input ctl_t done_c,
                           input int w, output bit ok);
    for (int i = 0; i < w && i < TO; i++) push(1'b0, st, wait_c);
    ok = (w < TO);
    if (ok) push(1'b1, st, done_c);
    else    err_kind = 2;
  endtask

  // Reference plan: the full expected cycle list for one instruction.
  task automatic plan(input logic [5:0] op, input int wf, input int wd);
    bit ok;
    exp_q.delete();
    err_kind = 0;
    mem_phase(4'd0, c_fetch(1'b0), c_fetch(1'b1), wf, ok);
    if (!ok) return;
    push(1'($urandom_range(0, 1)), 4'd1, c_decode());
    case (op)
      OP_R: begin
        push(1'($urandom_range(0, 1)), 4'd6, c_exec());
        push(1'($urandom_range(0, 1)), 4'd7, c_wb(2'd1));
      end
      OP_LW: begin
        push(1'($urandom_range(0, 1)), 4'd2, c_addr());
        mem_phase(4'd3, c_memread(), c_memread(), wd, ok);
        if (ok) push(1'($urandom_range(0, 1)), 4'd4, c_memwb());
      end
      OP_SW: begin
        push(1'($urandom_range(0, 1)), 4'd2, c_addr());
        mem_phase(4'd5, c_memwrite(1'b0), c_memwrite(1'b1), wd, ok);
      end
      OP_BEQ: push(1'($urandom_range(0, 1)), 4'd8, c_branch());
      OP_J:   push(1'($urandom_range(0, 1)), 4'd9, c_jump());
      OP_JAL: push(1'($urandom_range(0, 1)), 4'd12, c_jal());
      OP_ADDI: begin
        push(1'($urandom_range(0, 1)), 4'd10, c_addr());
        push(1'($urandom_range(0, 1)), 4'd11, c_wb(2'd0));
      end
      default: err_kind = 1;
    endcase
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] mcnt;
    int          wf, wd, r;

    reset_n = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
    repeat (2) @(posedge clock);

    // Reset in the middle of a MEMREAD wait: no retire, everything cleared.
    add(1, OP_LW, 1, 0, c_fetch(1), 0);
    add(1, OP_LW, 0, 1, c_decode(), 0);
    add(1, OP_LW, 0, 2, c_addr(), 0);
    add(1, OP_LW, 0, 3, c_memread(), 0);
    add(0, OP_LW, 0, 3, c_none(), 0);
    add(0, OP_LW, 0, 0, c_none(), 0);
    // R-type add, zero-wait memory: 4 cycles.
    add(1, OP_R, 1, 0, c_fetch(1), 0);
    add(1, OP_R, 1, 1, c_decode(), 0);
    add(1, OP_R, 1, 6, c_exec(), 0);
    add(1, OP_R, 1, 7, c_wb(2'd1), 0);
    // lw with 3 wait cycles in MEMREAD: 8 cycles.
    add(1, OP_LW, 1, 0, c_fetch(1), 1);
    add(1, OP_LW, 1, 1, c_decode(), 1);
    add(1, OP_LW, 1, 2, c_addr(), 1);
    for (int i = 0; i < 3; i++) add(1, OP_LW, 0, 3, c_memread(), 1);
    add(1, OP_LW, 1, 3, c_memread(), 1);
    add(1, OP_LW, 0, 4, c_memwb(), 1);
    // beq: 3 cycles.
    add(1, OP_BEQ, 1, 0, c_fetch(1), 2);
    add(1, OP_BEQ, 1, 1, c_decode(), 2);
    add(1, OP_BEQ, 1, 8, c_branch(), 2);
    // sw with one data wait: retires on the ready cycle.
    add(1, OP_SW, 1, 0, c_fetch(1), 3);
    add(1, OP_SW, 1, 1, c_decode(), 3);
    add(1, OP_SW, 1, 2, c_addr(), 3);
    add(1, OP_SW, 0, 5, c_memwrite(0), 3);
    add(1, OP_SW, 1, 5, c_memwrite(1), 3);
    // jal, j, addi.
    add(1, OP_JAL, 1, 0, c_fetch(1), 4);
    add(1, OP_JAL, 1, 1, c_decode(), 4);
    add(1, OP_JAL, 1, 12, c_jal(), 4);
    add(1, OP_J, 1, 0, c_fetch(1), 5);
    add(1, OP_J, 1, 1, c_decode(), 5);
    add(1, OP_J, 1, 9, c_jump(), 5);
    add(1, OP_ADDI, 1, 0, c_fetch(1), 6);
    add(1, OP_ADDI, 1, 1, c_decode(), 6);
    add(1, OP_ADDI, 1, 10, c_addr(), 6);
    add(1, OP_ADDI, 1, 11, c_wb(2'd0), 6);
    // Fetch with mem_ready on the last allowed cycle: no timeout.
    for (int i = 0; i < TO - 1; i++) add(1, OP_J, 0, 0, c_fetch(0), 7);
    add(1, OP_J, 1, 0, c_fetch(1), 7);
    add(1, OP_J, 0, 1, c_decode(), 7);
    add(1, OP_J, 0, 9, c_jump(), 7);

    foreach (tbl[i])
      do_cycle(tbl[i].rst_n, tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].ctl, tbl[i].cnt, 2'b00);
    $display("directed table: %0d vectors applied", tbl.size());

    // Illegal opcode: DECODE then an absorbing ERROR until reset.
    do_cycle(1, 6'h3F, 1, 0, c_fetch(1), 8, 2'b00);
    do_cycle(1, 6'h3F, 0, 1, c_decode(), 8, 2'b00);
    for (int i = 0; i < 11; i++) do_cycle(1, 6'h3F, 1'($urandom_range(0, 1)), 15, c_none(), 8, 2'b10);
    do_cycle(0, 6'h3F, 1, 15, c_none(), 8, 2'b10);
    $display("illegal opcode sequence done");

    // Fetch timeout after TO missed cycles.
    for (int i = 0; i < TO; i++) do_cycle(1, OP_R, 0, 0, c_fetch(0), 0, 2'b00);
    for (int i = 0; i < 2; i++) do_cycle(1, OP_R, 1, 15, c_none(), 0, 2'b01);
    do_cycle(0, OP_R, 0, 15, c_none(), 0, 2'b01);
    $display("fetch timeout sequence done");

    // Random instruction stream against the reference plan.
    mcnt = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if      (r < 3)  op = OP_R;
      else if (r < 6)  op = OP_LW;
      else if (r < 9)  op = OP_SW;
      else if (r < 11) op = OP_BEQ;
      else if (r < 13) op = OP_J;
      else if (r < 15) op = OP_JAL;
      else if (r < 18) op = OP_ADDI;
      else if (r == 18) op = 6'h10 + 6'($urandom_range(0, 7));
      else op = OP_R;
      wf = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1);
      wd = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1);
      plan(op, wf, wd);
      foreach (exp_q[i]) begin
        do_cycle(1, op, exp_q[i].rdy, exp_q[i].st, exp_q[i].ctl, mcnt, 2'b00);
        if (exp_q[i].ctl.instr_retired) mcnt = mcnt + 32'd1;
      end
      if (err_kind != 0) begin
        for (int i = 0; i < 3; i++)
          do_cycle(1, op, 1'($urandom_range(0, 1)), 15, c_none(), mcnt,
                   (err_kind == 1) ? 2'b10 : 2'b01);
        do_cycle(0, op, 0, 15, c_none(), mcnt, (err_kind == 1) ? 2'b10 : 2'b01);
        mcnt = 0;
      end
      $display("txn %0d op=%h wf=%0d wd=%0d cycles=%0d err=%0d", n, op, wf, wd,
               exp_q.size(), err_kind);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle sequencer for the MIPS datapath. It replaces single-cycle decode control with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared register file, ALU, muxes and a single unified memory port, which handles both instruction and data traffic. It handles variable-latency memory through a ready handshake, detects memory timeouts, and counts retired instructions.

## Interface
- MEM_TIMEOUT, default 16, number of wait cycles allowed for mem_ready before the error state is entered (range 1..255).
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- opcode  input  6  instruction[31:26], taken from the instruction register.
- funct  input  6  instruction[5:0].
- alu_zero  input  1  ALU zero flag, used in the BRANCH state.
- mem_ready  input  1  memory completes the current read or write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load when alu_zero is high (beq).
- pc_source  output  2  0 = ALU result, 1 = ALUOut register, 2 = jump target.
- ir_write  output  1  instruction register load.
- iord  output  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- mem_toreg  output  2  writeback source: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_dst  output  2  write address source: 0 = rt, 1 = rd, 2 = 31.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU operand A: 0 = PC, 1 = rs.
- alu_src_b  output  2  ALU operand B: 0 = rt, 1 = constant 4, 2 = sext(imm), 3 = sext(imm)<<2.
- alu_op  output  2  0 = add, 1 = sub, 2 = use funct.
- state  output  4  current state encoding, for debug.
- instr_retired  output  1  one-cycle pulse on the final cycle of each instruction.
- retired_count  output  32  count of retired instructions; wraps from 0xFFFFFFFF to 0.
- err_illegal_opcode  output  1  sticky; set on entry to the ERROR state from DECODE.
- err_mem_timeout  output  1  sticky; set on entry to the ERROR state from a memory wait.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADDR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTE = 6, RTYPEWB = 7, BRANCH = 8, JUMP = 9, IMMEXEC = 10, IMMWB = 11, JAL = 12, ERROR = 15.
- FETCH:
  - Drives mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 0, pc_source = 0.
  - ir_write and pc_write are asserted only in the cycle where mem_ready = 1 (Mealy); the FSM then advances to DECODE.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 3, alu_op = 0, which computes the branch target into ALUOut.
  - Dispatch on opcode: 0x00 to EXECUTE; 0x23 or 0x2B to MEMADDR; 0x04 to BRANCH; 0x02 to JUMP; 0x03 to JAL; 0x08 to IMMEXEC.
  - Any other opcode goes to ERROR.
- MEMADDR:
  - Drives alu_src_a = 1, alu_src_b = 2, alu_op = 0.
  - Next state is MEMREAD for 0x23, MEMWRITE for 0x2B.
- MEMREAD: drives mem_read = 1, iord = 1; stays in the state until mem_ready = 1, then goes to MEMWB.
- MEMWB: drives reg_write = 1, reg_dst = 0, mem_toreg = 1; retires, then goes to FETCH.
- MEMWRITE: drives mem_write = 1, iord = 1; waits for mem_ready, retires in that same cycle, then goes to FETCH.
- EXECUTE then RTYPEWB:
  - EXECUTE drives alu_src_a = 1, alu_src_b = 0, alu_op = 2.
  - RTYPEWB drives reg_write = 1, reg_dst = 1, mem_toreg = 0; retires.
- IMMEXEC then IMMWB:
  - IMMEXEC drives alu_src_a = 1, alu_src_b = 2, alu_op = 0.
  - IMMWB drives reg_write = 1, reg_dst = 0, mem_toreg = 0; retires.
- BRANCH: drives alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_write_cond = 1, pc_source = 1; retires.
- JUMP: drives pc_write = 1, pc_source = 2; retires.
- JAL: drives reg_write = 1, reg_dst = 2, mem_toreg = 2, pc_write = 1, pc_source = 2; retires.
- ERROR: absorbing state; all enables are 0. Only reset exits it.
- Any output not listed for a state is 0.
- Wait counter:
  - 8 bits; cleared on entry to FETCH, MEMREAD and MEMWRITE; incremented each cycle mem_ready = 0 while in one of those states.
  - If it reaches MEM_TIMEOUT with mem_ready still 0, the next state is ERROR and err_mem_timeout is set.
  - mem_ready = 1 on the MEM_TIMEOUT-th cycle takes priority over the timeout.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- retired_count increments by 1 in each cycle where instr_retired = 1.

## Timing
- While reset_n = 0 at a clock edge, the next state is FETCH and the wait counter, retired_count, err_illegal_opcode and err_mem_timeout are all cleared.
- During the reset cycle all enables are forced to 0. state reads 0 after reset.
- A reset asserted mid-instruction, including during a memory wait, abandons the instruction with no retire pulse.
- Cycle counts with zero-wait memory (mem_ready tied to 1):
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j, jal: 3
- Each memory wait cycle adds exactly 1 cycle.
- No write enables (reg_write, mem_write, pc_write, ir_write) are asserted in DECODE or ERROR.

## Test plan
- reset_n low for 2 cycles mid-MEMREAD, mem_ready = 0 → state = 0, all enables 0, retired_count = 0, no retire pulse.
- R-type add (opcode 0x00, funct 0x20), mem_ready = 1 → states 0, 1, 6, 7; reg_write = 1 with reg_dst = 1 in cycle 4; instr_retired pulses once.
- lw (0x23) with mem_ready delayed 3 cycles in MEMREAD → 8 total cycles; mem_read held high through the wait; MEMWB drives mem_toreg = 1.
- beq (0x04) → 3 cycles; pc_write_cond = 1 and pc_source = 1 in BRANCH; pc_write = 0 in that cycle.
- opcode 0x3F → DECODE then ERROR (state = 15); err_illegal_opcode = 1; state stays at 15 with no enables for 10 more cycles; cleared by reset.
- FETCH with mem_ready = 0 and MEM_TIMEOUT = 4 → ERROR after 4 wait cycles, err_mem_timeout = 1; a rerun with mem_ready = 1 on the 4th cycle → DECODE, no error.
